lsu_mem_if: RTL and testbench

Multi-cycle load/store unit between the single-cycle datapath's control decoder and an external data memory with a req/ack handshake. Consumes the decoder's MemRead, MemWrite and 4-bit `ls` width code, aligns stores onto byte lanes, and extracts and extends load data. Stalls the PC and register-file write while a memory transaction is outstanding. Flags misaligned accesses and memory timeouts.

---
 rtl/lsu_mem_if.sv | 172 +++++++++++++++++
 tb/tb_lsu_mem_if.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
// Load/store unit bridging the single-cycle datapath to a req/ack data memory.
// Aligns stores onto byte lanes, extends loads, stalls the core while busy.
module lsu_mem_if #(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [3:0]  ls,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        done,
   output logic        err,
   output logic        misalign,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
   localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t        state_q, state_d;
   logic          req_q, req_d, we_q, we_d, done_q, done_d, err_q, err_d, uns_q, uns_d;
   logic [31:0]   addr_q, addr_d, wd_q, wd_d, rdata_q, rdata_d;
   logic [3:0]    be_q, be_d;
   logic [1:0]    sz_q, sz_d, off_q, off_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic        access, mis_addr, in_uns;
   logic [1:0]  in_sz;
   logic [3:0]  in_be;
   logic [31:0] in_wd, load_ext;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Decode of the instruction currently presented by the control decoder
   always_comb begin
      access = MemRead | MemWrite;
      in_uns = (ls == 4'b0010) || (ls == 4'b0001);
      if ((ls == 4'b0100) || (ls == 4'b0001))      in_sz = SZ_B;
      else if ((ls == 4'b1000) || (ls == 4'b0010)) in_sz = SZ_H;
      else                                         in_sz = SZ_W;
      case (in_sz)
         SZ_B: begin
            mis_addr = 1'b0;
            in_be    = 4'b0001 << addr[1:0];
            in_wd    = {4{wdata[7:0]}};
         end
         SZ_H: begin
            mis_addr = addr[0];
            in_be    = 4'b0011 << {addr[1], 1'b0};
            in_wd    = {2{wdata[15:0]}};
         end
         default: begin
            mis_addr = |addr[1:0];
            in_be    = 4'b1111;
            in_wd    = wdata;
         end
      endcase
   end

   // Load extraction uses the width and offset latched with the request
   always_comb begin
      lane_b = mem_rdata[{off_q, 3'b000} +: 8];
      lane_h = mem_rdata[{off_q[1], 4'b0000} +: 16];
      case (sz_q)
         SZ_B:    load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
         SZ_H:    load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wd_d    = wd_q;
      sz_d    = sz_q;
      uns_d   = uns_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (access && !mis_addr) begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = MemWrite;
            addr_d  = {addr[31:2], 2'b00};
            be_d    = in_be;
            wd_d    = in_wd;
            sz_d    = in_sz;
            uns_d   = in_uns;
            off_d   = addr[1:0];
            cnt_d   = '0;
         end
         REQ: if (mem_ack) begin
            state_d = DONE;
            req_d   = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b0;
            rdata_d = we_q ? 32'd0 : load_ext;
         end else if (cnt_q == WAIT_LAST) begin
            state_d = DONE;
            req_d   = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'd0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wd_q    <= '0;
         sz_q    <= SZ_B;
         uns_q   <= 1'b0;
         off_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wd_q    <= wd_d;
         sz_q    <= sz_d;
         uns_q   <= uns_d;
         off_q   <= off_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Stall is combinational so the PC is held on the request cycle itself
   assign stall     = ((state_q == IDLE) & access & ~mis_addr) | (state_q == REQ);
   assign misalign  = access & mis_addr;
   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_be    = be_q;
   assign mem_wdata = wd_q;
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: loads/stores, waits, timeout, reset, misalign.
module tb_lsu_mem_if;
   localparam int MW = 4;

   logic        clk = 1'b0, rstn = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0, mem_ack = 1'b0;
   logic [3:0]  ls = 4'b0;
   logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
   logic        stall, done, err, misalign, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   int          n_chk = 0, n_fail = 0;

   lsu_mem_if #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rstn(rstn), .MemRead(MemRead), .MemWrite(MemWrite), .ls(ls),
      .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .done(done),
      .err(err), .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full access; waits = REQ cycles without ack (>= MW means timeout)
   task automatic run_acc(input string tag, input logic rd, input logic wr,
                          input logic [3:0] lsv, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdw, input int waits,
                          input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] erd, input logic eerr);
      MemRead = rd; MemWrite = wr; ls = lsv; addr = a; wdata = wd; mem_rdata = rdw;
      #1;
      check({tag, ":stall_idle"}, 32'(stall), 32'd1);
      check({tag, ":misalign"}, 32'(misalign), 32'd0);
      check({tag, ":req_idle"}, 32'(mem_req), 32'd0);
      step();
      for (int i = 0; i < MW; i++) begin
         check({tag, ":req"}, 32'(mem_req), 32'd1);
         check({tag, ":we"}, 32'(mem_we), 32'(wr));
         check({tag, ":be"}, 32'(mem_be), 32'(ebe));
         check({tag, ":addr"}, mem_addr, {a[31:2], 2'b00});
         if (wr) check({tag, ":wdata"}, mem_wdata, ewd);
         check({tag, ":stall_req"}, 32'(stall), 32'd1);
         check({tag, ":done_req"}, 32'(done), 32'd0);
         if (i == waits) mem_ack = 1'b1;
         step();
         mem_ack = 1'b0;
         if (i == waits) break;
      end
      check({tag, ":done"}, 32'(done), 32'd1);
      check({tag, ":err"}, 32'(err), 32'(eerr));
      check({tag, ":rdata"}, rdata, erd);
      check({tag, ":req_done"}, 32'(mem_req), 32'd0);
      check({tag, ":stall_done"}, 32'(stall), 32'd0);
      MemRead = 1'b0; MemWrite = 1'b0;
      step();
      check({tag, ":done_pulse"}, 32'(done), 32'd0);
      check({tag, ":rdata_hold"}, rdata, erd);
   endtask

   initial begin
      #1;
      check("rst:req", 32'(mem_req), 32'd0);
      check("rst:done", 32'(done), 32'd0);
      check("rst:err", 32'(err), 32'd0);
      check("rst:rdata", rdata, 32'd0);
      check("rst:be", 32'(mem_be), 32'd0);
      step();
      rstn = 1'b1;
      step();

      run_acc("lb",  1, 0, 4'b0100, 32'h103, 0, 32'h80FF_1234, 0, 4'b1000, 0, 32'hFFFF_FF80, 0);
      run_acc("lhu", 1, 0, 4'b0010, 32'h102, 0, 32'h9ABC_0000, 3, 4'b1100, 0, 32'h0000_9ABC, 0);
      run_acc("lh",  1, 0, 4'b1000, 32'h100, 0, 32'h1234_8001, 1, 4'b0011, 0, 32'hFFFF_8001, 0);
      run_acc("lbu", 1, 0, 4'b0001, 32'h202, 0, 32'h00F7_0000, 0, 4'b0100, 0, 32'h0000_00F7, 0);
      run_acc("sb",  0, 1, 4'b0100, 32'h201, 32'h1234_56A5, 32'hFFFF_FFFF, 0, 4'b0010, 32'hA5A5_A5A5, 0, 0);
      run_acc("lw",  1, 0, 4'b0000, 32'h104, 0, 32'hCAFE_F00D, 2, 4'b1111, 0, 32'hCAFE_F00D, 0);
      run_acc("sh",  0, 1, 4'b1000, 32'h202, 32'h1234_56A5, 32'hFFFF_FFFF, 0, 4'b1100, 32'h56A5_56A5, 0, 0);
      run_acc("both", 1, 1, 4'b0000, 32'h400, 32'hDEAD_BEEF, 32'h5555_5555, 0, 4'b1111, 32'hDEAD_BEEF, 0, 0);
      run_acc("lw_mid", 1, 0, 4'b0111, 32'h108, 0, 32'h0BAD_CAFE, 1, 4'b1111, 0, 32'h0BAD_CAFE, 0);
      run_acc("tmo", 1, 0, 4'b0000, 32'h600, 0, 32'h1111_1111, MW, 4'b1111, 0, 32'h0, 1);

      // Reset in the middle of an outstanding request
      MemRead = 1'b1; ls = 4'b0000; addr = 32'h500;
      step();
      check("rstmid:req_before", 32'(mem_req), 32'd1);
      step();
      MemRead = 1'b0;
      rstn = 1'b0;
      #1;
      check("rstmid:req", 32'(mem_req), 32'd0);
      check("rstmid:stall", 32'(stall), 32'd0);
      check("rstmid:err", 32'(err), 32'd0);
      check("rstmid:addr", mem_addr, 32'd0);
      step();
      rstn = 1'b1;
      step();
      check("rstmid:idle_req", 32'(mem_req), 32'd0);

      // Ack while idle must be ignored
      mem_ack = 1'b1;
      step();
      check("ackidle:done1", 32'(done), 32'd0);
      step();
      check("ackidle:done2", 32'(done), 32'd0);
      mem_ack = 1'b0;

      // Misaligned accesses: flagged, no stall, no request
      MemRead = 1'b1; ls = 4'b0000; addr = 32'h302;
      #1;
      check("mis_lw:flag", 32'(misalign), 32'd1);
      check("mis_lw:stall", 32'(stall), 32'd0);
      step();
      check("mis_lw:req", 32'(mem_req), 32'd0);
      check("mis_lw:done", 32'(done), 32'd0);
      ls = 4'b1000; addr = 32'h301;
      #1;
      check("mis_lh:flag", 32'(misalign), 32'd1);
      check("mis_lh:stall", 32'(stall), 32'd0);
      step();
      check("mis_lh:req", 32'(mem_req), 32'd0);
      check("mis_lh:done", 32'(done), 32'd0);
      ls = 4'b0100; addr = 32'h303;
      #1;
      check("ok_lb:flag", 32'(misalign), 32'd0);
      MemRead = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
